// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// operation encodings, FSM state type and the default datapath width.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    FIX  = 2'b11
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the magnitude datapath: a shift-add multiply step or a
// restoring divide step on a 2*WIDTH accumulator.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               div_mode,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               q_bit
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;

  // Multiply: acc = {partial, multiplier}; add on LSB, then shift right with carry.
  // Divide:   acc = {remainder, dividend/quotient}; quotient bits enter at the LSB.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? operand : {WIDTH{1'b0}})};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, operand};
    div_ge    = (div_shift >= {1'b0, operand});
    div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    acc_next  = {mul_sum, acc[WIDTH-1:1]};
    q_bit     = 1'b0;
    if (div_mode) begin
      acc_next = {div_rem, acc[WIDTH-2:0], div_ge};
      q_bit    = div_ge;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer owning HI/LO: one bit per cycle on
// operand magnitudes, with a final sign-fixup cycle before the HI/LO write.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             we,
  input  logic             hilo_sel,
  input  logic [WIDTH-1:0] wdata,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   opnd_reg;
  logic [1:0]         op_reg;
  logic               sign_a_reg, sign_b_reg, b_zero_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;
  logic               done_reg;
  logic               q_bit;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] fix_result;
  logic [WIDTH-1:0]   fix_quo, fix_rem;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_reg),
    .operand  (opnd_reg),
    .div_mode (state_reg == DIV),
    .acc_next (acc_next),
    .q_bit    (q_bit)
  );

  always_comb begin
    a_neg = op[0] & src_a[WIDTH-1];
    b_neg = op[0] & src_b[WIDTH-1];
    a_mag = a_neg ? -src_a : src_a;
    b_mag = b_neg ? -src_b : src_b;
  end

  // Divide by zero leaves an all-ones quotient; only the remainder follows
  // the dividend sign, which reproduces src_a exactly.
  always_comb begin
    fix_quo = acc_reg[WIDTH-1:0];
    fix_rem = acc_reg[2*WIDTH-1:WIDTH];
    if ((sign_a_reg ^ sign_b_reg) && !b_zero_reg) fix_quo = -fix_quo;
    if (sign_a_reg) fix_rem = -fix_rem;
    if (op_reg[1]) fix_result = {fix_rem, fix_quo};
    else if (sign_a_reg ^ sign_b_reg) fix_result = -acc_reg;
    else fix_result = acc_reg;
  end

  always_ff @(posedge clk) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start && !cancel) state_next = op[1] ? DIV : MUL;
      MUL, DIV: begin
        if (cancel) state_next = IDLE;
        else if (cnt_reg == CNT_W'(1)) state_next = FIX;
      end
      FIX: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_reg    <= '0;
      acc_reg    <= '0;
      opnd_reg   <= '0;
      op_reg     <= '0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      b_zero_reg <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (we) begin
            if (hilo_sel) hi_reg <= wdata;
            else          lo_reg <= wdata;
          end
          if (start && !cancel) begin
            op_reg     <= op;
            sign_a_reg <= a_neg;
            sign_b_reg <= b_neg;
            b_zero_reg <= (src_b == '0);
            cnt_reg    <= CNT_W'(WIDTH);
            if (op[1]) begin
              acc_reg  <= {{WIDTH{1'b0}}, a_mag};
              opnd_reg <= b_mag;
            end else begin
              acc_reg  <= {{WIDTH{1'b0}}, b_mag};
              opnd_reg <= a_mag;
            end
          end
        end
        MUL, DIV: begin
          if (!cancel) begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        FIX: begin
          if (!cancel) begin
            hi_reg   <= fix_result[2*WIDTH-1:WIDTH];
            lo_reg   <= fix_result[WIDTH-1:0];
            done_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: a vector table of operations with
// hand-computed HI/LO plus sequences for writes, cancel, back-to-back, reset.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, we, hilo_sel, cancel;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total_checks = 0;
  int passed_checks = 0;

  muldiv_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .we(we), .hilo_sel(hilo_sel),
    .wdata(wdata), .cancel(cancel), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act === exp) passed_checks++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches an op in the current cycle and waits for done; checks latency,
  // busy throughout, and the resulting HI/LO.
  task automatic run_op(input int idx, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int lat;
    bit busy_ok;
    lat = 0;
    busy_ok = 1'b1;
    start = 1'b1; op = o; src_a = a; src_b = b;
    tick();
    start = 1'b0;
    src_a = $urandom; src_b = $urandom;
    for (int k = 1; k <= 100; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      tick();
    end
    $display("op %0d: op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h lat=%0d",
             idx, o, a, b, hi, lo, lat);
    check($sformatf("latency[%0d]", idx), 32'(lat), 32'd34);
    check($sformatf("busy_during[%0d]", idx), {31'd0, busy_ok}, 32'd1);
    check($sformatf("busy_at_done[%0d]", idx), {31'd0, busy}, 32'd0);
    check($sformatf("hi[%0d]", idx), hi, eh);
    check($sformatf("lo[%0d]", idx), lo, el);
  endtask

  initial begin
    logic [31:0] keep_hi, keep_lo;
    bit saw_done;

    vecs[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4] = '{OP_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
    vecs[5] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[6] = '{OP_DIV,   32'hFFFFFF9C, 32'd0,        32'hFFFFFF9C, 32'hFFFFFFFF};
    vecs[7] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};

    reset = 1'b0; start = 1'b0; we = 1'b0; hilo_sel = 1'b0; cancel = 1'b0;
    op = 2'b00; src_a = '0; src_b = '0; wdata = '0;
    tick(); tick();
    reset = 1'b1;
    $display("reset: busy=%0b done=%0b hi=0x%08h lo=0x%08h", busy, done, hi, lo);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    for (int i = 0; i < 9; i++)
      run_op(i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo);

    // Back-to-back: start in the done cycle of the last vector.
    run_op(9, OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

    // Direct writes in IDLE.
    keep_lo = lo;
    we = 1'b1; hilo_sel = 1'b1; wdata = 32'h1234;
    tick();
    we = 1'b0;
    $display("mthi: hi=0x%08h lo=0x%08h", hi, lo);
    check("mthi_hi", hi, 32'h1234);
    check("mthi_lo", lo, keep_lo);
    we = 1'b1; hilo_sel = 1'b0; wdata = 32'h5678;
    tick();
    we = 1'b0;
    $display("mtlo: hi=0x%08h lo=0x%08h", hi, lo);
    check("mtlo_lo", lo, 32'h5678);
    check("mtlo_hi", hi, 32'h1234);

    // we while busy is ignored.
    start = 1'b1; op = OP_MULTU; src_a = 32'd3; src_b = 32'd5;
    tick();
    start = 1'b0;
    repeat (4) tick();
    we = 1'b1; hilo_sel = 1'b1; wdata = 32'hDEAD;
    tick();
    we = 1'b0;
    $display("we_busy: hi=0x%08h lo=0x%08h", hi, lo);
    check("we_busy_hi", hi, 32'h1234);
    check("we_busy_lo", lo, 32'h5678);
    saw_done = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (done) begin saw_done = 1'b1; break; end
      tick();
    end
    check("we_busy_done", {31'd0, saw_done}, 32'd1);
    check("we_busy_res_lo", lo, 32'd15);
    tick();

    // we and start in the same cycle: write lands, then FIX overwrites.
    we = 1'b1; hilo_sel = 1'b1; wdata = 32'hAAAA;
    start = 1'b1; op = OP_MULTU; src_a = 32'd2; src_b = 32'd3;
    tick();
    we = 1'b0; start = 1'b0;
    $display("we_start: hi=0x%08h busy=%0b", hi, busy);
    check("we_start_hi", hi, 32'hAAAA);
    check("we_start_busy", {31'd0, busy}, 32'd1);
    saw_done = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (done) begin saw_done = 1'b1; break; end
      tick();
    end
    check("we_start_done", {31'd0, saw_done}, 32'd1);
    check("we_start_res_hi", hi, 32'd0);
    check("we_start_res_lo", lo, 32'd6);
    tick();

    // Cancel at cycle 10 of a DIV.
    keep_hi = hi; keep_lo = lo;
    start = 1'b1; op = OP_DIVU; src_a = 32'd1000; src_b = 32'd3;
    tick();
    start = 1'b0;
    repeat (9) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    $display("cancel: busy=%0b", busy);
    check("cancel_busy", {31'd0, busy}, 32'd0);
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    check("cancel_no_done", {31'd0, saw_done}, 32'd0);
    check("cancel_hi", hi, keep_hi);
    check("cancel_lo", lo, keep_lo);

    // cancel and start together: nothing launches.
    cancel = 1'b1; start = 1'b1; op = OP_MULT; src_a = 32'd9; src_b = 32'd9;
    tick();
    cancel = 1'b0; start = 1'b0;
    $display("cancel_start: busy=%0b", busy);
    check("cancel_start_busy", {31'd0, busy}, 32'd0);

    // Reset mid-MUL.
    start = 1'b1; op = OP_MULTU; src_a = 32'd11; src_b = 32'd13;
    tick();
    start = 1'b0;
    repeat (5) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    $display("reset_mid: busy=%0b hi=0x%08h lo=0x%08h", busy, hi, lo);
    check("reset_mid_busy", {31'd0, busy}, 32'd0);
    check("reset_mid_hi", hi, 32'd0);
    check("reset_mid_lo", lo, 32'd0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
